pll_reset_ctrl: RTL and testbench

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 143 ++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// system reset. Lock loss in RUN restarts the sequence; repeated lock timeouts latch FAIL.
module pll_reset_ctrl #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       clear_stats,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned MaxRs  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                   PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned CntMax = (MaxRs > LOCK_TIMEOUT_CYCLES) ? MaxRs : LOCK_TIMEOUT_CYCLES;
  // The counter only ever reaches CntMax-1.
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      MaxRetry    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            sync_q, lock_s_q;
  logic            loss_inc;
  logic            pll_rst_q, sys_rst_n_q, ready_q, fail_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    retry_d  = retry_q;
    loss_inc = 1'b0;
    unique case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (lock_s_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
          if (retry_q == MaxRetry) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = StResetPll;
          end
        end
      end
      StStable: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s_q) begin
          state_d  = StResetPll;
          loss_inc = 1'b1;
        end
      end
      StFail: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StResetPll;
        cnt_d   = '0;
      end
    endcase

    // A clear on the same cycle as a lock loss wins.
    if (clear_stats) begin
      loss_d = '0;
    end else if (loss_inc && (loss_q != 8'hff)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= StResetPll;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync_q      <= pll_locked;
      lock_s_q    <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == StResetPll) || (state_d == StFail);
      sys_rst_n_q <= (state_d == StRun);
      ready_q     <= (state_d == StRun);
      fail_q      <= (state_d == StFail);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: per-cycle vector table for the reset/lock/timeout sequences,
// plus hand-written sequences for lock loss, loss counter saturation/clear and async reset.
module tb_pll_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clear_stats = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .clear_stats(clear_stats),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #10 refclk = ~refclk;

  typedef struct {
    bit          rst;     // pulse rst_n just before this vector's edge
    bit          locked;
    bit          clr;
    logic [15:0] exp;     // {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt}
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] pk(bit p, bit s, bit r, bit f, int rc, int lc);
    return {p, s, r, f, 4'(rc), 8'(lc)};
  endfunction

  function automatic logic [15:0] obs();
    return {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d loss=%0d, want pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d loss=%0d",
               name, got[15], got[14], got[13], got[12], got[11:8], got[7:0],
               want[15], want[14], want[13], want[12], want[11:8], want[7:0]);
    end
  endtask

  task automatic add(input int n, input bit rst, input bit lk, input bit clr,
                     input logic [15:0] e);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst    = rst && (i == 0);
      v.locked = lk;
      v.clr    = clr;
      v.exp    = e;
      vecs.push_back(v);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Called just after an edge: asserts reset with no clock edge, checks, releases before next edge.
  task automatic apply_reset(input string name);
    rst_n = 1'b0;
    #2;
    check(name, obs(), pk(1, 0, 0, 0, 0, 0));
    #5;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int max_cycles);
    int k = 0;
    while (!ready && k < max_cycles) begin
      step();
      k++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: ready=%b after %0d cycles, want 1", name, ready, k);
    end
  endtask

  task automatic do_loss();
    pll_locked = 1'b0;
    repeat (3) step();
    pll_locked = 1'b1;
    wait_ready("relock", 40);
  endtask

  initial begin
    // Lock raised 10 cycles after reset release.
    add(3,  1, 0, 0, pk(1, 0, 0, 0, 0, 0));
    add(7,  0, 0, 0, pk(0, 0, 0, 0, 0, 0));
    add(10, 0, 1, 0, pk(0, 0, 0, 0, 0, 0));
    add(3,  0, 1, 0, pk(0, 1, 1, 0, 0, 0));
    // Lock held from reset; one-cycle dropout in the 5th STABLE cycle forces a fresh STABLE.
    add(3,  1, 1, 0, pk(1, 0, 0, 0, 0, 0));
    add(6,  0, 1, 0, pk(0, 0, 0, 0, 0, 0));
    add(1,  0, 0, 0, pk(0, 0, 0, 0, 0, 0));
    add(10, 0, 1, 0, pk(0, 0, 0, 0, 0, 0));
    add(3,  0, 1, 0, pk(0, 1, 1, 0, 0, 0));
    // Never locks: three 4-cycle pulses, 32-cycle waits, then FAIL.
    add(3,  1, 0, 0, pk(1, 0, 0, 0, 0, 0));
    add(32, 0, 0, 0, pk(0, 0, 0, 0, 0, 0));
    add(4,  0, 0, 0, pk(1, 0, 0, 0, 1, 0));
    add(32, 0, 0, 0, pk(0, 0, 0, 0, 1, 0));
    add(4,  0, 0, 0, pk(1, 0, 0, 0, 2, 0));
    add(32, 0, 0, 0, pk(0, 0, 0, 0, 2, 0));
    add(10, 0, 0, 0, pk(1, 0, 0, 1, 2, 0));

    #1;
    foreach (vecs[i]) begin
      pll_locked  = vecs[i].locked;
      clear_stats = vecs[i].clr;
      if (vecs[i].rst) apply_reset($sformatf("reset_before_vec%0d", i));
      step();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Reset out of FAIL, lock from the start; RUN at the 13th edge.
    pll_locked = 1'b1;
    apply_reset("reset_from_fail");
    wait_ready("first_run", 40);

    // Lock loss in RUN: sys_rst_n falls on the 3rd edge after the pin change.
    pll_locked = 1'b0;
    step();
    check("loss_edge1", obs(), pk(0, 1, 1, 0, 0, 0));
    step();
    check("loss_edge2", obs(), pk(0, 1, 1, 0, 0, 0));
    step();
    check("loss_edge3", obs(), pk(1, 0, 0, 0, 0, 1));
    pll_locked = 1'b1;
    for (int e = 4; e <= 16; e++) begin
      step();
      if (e <= 6) check($sformatf("loss_pulse_e%0d", e), obs(), pk(1, 0, 0, 0, 0, 1));
      else if (e == 7 || e == 15) check($sformatf("loss_wait_e%0d", e), obs(), pk(0, 0, 0, 0, 0, 1));
      else if (e == 16) check("loss_relock_run", obs(), pk(0, 1, 1, 0, 0, 1));
    end

    // Saturation of the loss counter.
    repeat (254) do_loss();
    check("loss_255", obs(), pk(0, 1, 1, 0, 0, 255));
    do_loss();
    check("loss_saturated", obs(), pk(0, 1, 1, 0, 0, 255));

    // clear_stats on the very edge of a loss.
    pll_locked = 1'b0;
    step();
    step();
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clear_beats_inc", obs(), pk(1, 0, 0, 0, 0, 0));
    pll_locked = 1'b1;
    wait_ready("relock_after_clear", 40);
    do_loss();
    check("loss_after_clear", obs(), pk(0, 1, 1, 0, 0, 1));

    // Asynchronous reset mid-RUN, between edges.
    @(negedge refclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_run", obs(), pk(1, 0, 0, 0, 0, 0));

    // A timeout followed by lock: retry_cnt clears on entry to RUN.
    pll_locked = 1'b0;
    #4;
    rst_n = 1'b1;
    repeat (36) step();
    check("retry_after_timeout", obs(), pk(1, 0, 0, 0, 1, 0));
    pll_locked = 1'b1;
    wait_ready("run_after_retry", 60);
    check("retry_cleared_in_run", obs(), pk(0, 1, 1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
